// File: rtl/shiftreg_pkg.sv
// rtl/shiftreg_pkg.sv - shared types and defaults for the shift-register stimulus serializer
package shiftreg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } ser_state_e;

  localparam int SER_WIDTH_DEFAULT = 24;
  localparam int SER_GAP_DEFAULT   = 2;

endpackage

// File: rtl/shiftreg_bit_timer.sv
// rtl/shiftreg_bit_timer.sv - bit-period counter, wraps to 0 after reaching the period value
module shiftreg_bit_timer #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             start,
  input  logic [DIV_W-1:0] period,
  output logic             bit_start,
  output logic             bit_last
);

  logic [DIV_W-1:0] cnt;

  assign bit_last  = (cnt == period);
  // High when the following cycle is the first cycle of a bit period.
  assign bit_start = start || bit_last;

  always_ff @(posedge clk) begin
    if (reset_i || start || bit_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shiftreg_serializer.sv
// rtl/shiftreg_serializer.sv - parallel word to serial line with trigger, bit strobe and frame-done pulse
module shiftreg_serializer
  import shiftreg_pkg::*;
#(
  parameter int WIDTH      = SER_WIDTH_DEFAULT,
  parameter int DIV_W      = 8,
  parameter int GAP_CYCLES = SER_GAP_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [DIV_W-1:0] div_i,
  input  logic             msb_first_i,
  output logic             sdata_o,
  output logic             sbit_valid_o,
  output logic             trigger_o,
  output logic             frame_done_o,
  output logic             busy_o
);

  localparam int              IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  ser_state_e       state, next_state;
  logic [WIDTH-1:0] sreg;
  logic [DIV_W-1:0] div_q;
  logic             msb_q;
  logic [IDX_W-1:0] bit_idx;
  logic [3:0]       gap_cnt;
  logic             accept, bit_start, bit_last, last_bit;
  logic             ready_d, sdata_d, sbit_d, trig_d, done_d, busy_d;

  // ready_o gates accept so the cycle right after reset never accepts.
  assign accept   = (state == IDLE) && ready_o && valid_i;
  assign last_bit = bit_last && (bit_idx == LAST_IDX);

  shiftreg_bit_timer #(.DIV_W(DIV_W)) u_bit_timer (
    .clk      (clk),
    .reset_i  (reset_i),
    .start    (accept),
    .period   (div_q),
    .bit_start(bit_start),
    .bit_last (bit_last)
  );

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = DONE;
      DONE:    next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GAP_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next-cycle output values; registered below so every output is a flop.
  always_comb begin
    ready_d = (next_state == IDLE);
    busy_d  = (next_state != IDLE);
    done_d  = (next_state == DONE);
    trig_d  = accept;
    sbit_d  = bit_start && (next_state == SHIFT);
    sdata_d = 1'b0;
    if (accept) begin
      sdata_d = msb_first_i ? data_i[WIDTH-1] : data_i[0];
    end else if (next_state == SHIFT) begin
      sdata_d = bit_last ? (msb_q ? sreg[WIDTH-1] : sreg[0]) : sdata_o;
    end
  end

  // sreg holds the bits not yet presented, next bit always at the exit end.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      sreg    <= '0;
      div_q   <= '0;
      msb_q   <= 1'b0;
      bit_idx <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        sreg    <= msb_first_i ? {data_i[WIDTH-2:0], 1'b0} : (data_i >> 1);
        div_q   <= div_i;
        msb_q   <= msb_first_i;
        bit_idx <= '0;
      end else if ((state == SHIFT) && bit_last) begin
        sreg    <= msb_q ? {sreg[WIDTH-2:0], 1'b0} : (sreg >> 1);
        bit_idx <= bit_idx + 1'b1;
      end
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      ready_o      <= 1'b0;
      sdata_o      <= 1'b0;
      sbit_valid_o <= 1'b0;
      trigger_o    <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      ready_o      <= ready_d;
      sdata_o      <= sdata_d;
      sbit_valid_o <= sbit_d;
      trigger_o    <= trig_d;
      frame_done_o <= done_d;
      busy_o       <= busy_d;
    end
  end

endmodule

// File: tb/tb_shiftreg_serializer.sv
// tb/tb_shiftreg_serializer.sv - randomized self-checking bench against a cycle-timeline model
module tb_shiftreg_serializer;

  localparam int WIDTH = 24;
  localparam int DIV_W = 8;
  localparam int GAP   = 2;

  logic             clk;
  logic             reset_i;
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;
  logic [DIV_W-1:0] div_i;
  logic             msb_first_i;
  logic             sdata_o;
  logic             sbit_valid_o;
  logic             trigger_o;
  logic             frame_done_o;
  logic             busy_o;

  shiftreg_serializer #(.WIDTH(WIDTH), .DIV_W(DIV_W), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .div_i       (div_i),
    .msb_first_i (msb_first_i),
    .sdata_o     (sdata_o),
    .sbit_valid_o(sbit_valid_o),
    .trigger_o   (trigger_o),
    .frame_done_o(frame_done_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a frame is the accept cycle plus the word/div/order latched there.
  int               m_n      = -1;
  int               m_div    = 0;
  int               last_rst = -10;
  logic [WIDTH-1:0] m_word   = '0;
  bit               m_msb    = 1'b0;
  bit               accepted = 1'b0;

  int               last_trig = -1;
  int               prev_trig = -1;
  int               last_done = -1;
  int               done_cnt  = 0;
  int               sbit_cnt  = 0;
  int               one_cnt   = 0;
  logic             prev_ready = 1'b0;
  int               rise_q[$];
  logic [WIDTH-1:0] basic_bits = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {ready, sdata, sbit_valid, trigger, frame_done, busy} in cycle t.
  function automatic logic [5:0] expv(input int t);
    int   p, rel, k;
    logic b;
    if (t == last_rst + 1) return 6'b000000;
    if (m_n < 0) return 6'b100000;
    p   = WIDTH * (m_div + 1);
    rel = t - m_n - 1;
    if (rel < 0) return 6'b100000;
    if (rel < p) begin
      k = rel / (m_div + 1);
      b = m_msb ? m_word[WIDTH-1-k] : m_word[k];
      return {1'b0, b, (rel % (m_div + 1)) == 0, rel == 0, 1'b0, 1'b1};
    end
    if (rel == p) return 6'b000011;
    if (rel <= p + GAP) return 6'b000001;
    return 6'b100000;
  endfunction

  task automatic step();
    logic [5:0] e, o;
    @(posedge clk);
    e = expv(cyc);
    if (reset_i) begin
      last_rst = cyc;
      m_n      = -1;
    end else if (valid_i && e[5]) begin
      m_n      = cyc;
      m_word   = data_i;
      m_div    = int'(div_i);
      m_msb    = msb_first_i;
      accepted = 1'b1;
    end
    cyc++;
    @(negedge clk);
    e = expv(cyc);
    o = {ready_o, sdata_o, sbit_valid_o, trigger_o, frame_done_o, busy_o};
    check($sformatf("outs@%0d", cyc), 32'(o), 32'(e));
    if (trigger_o) begin
      prev_trig = last_trig;
      last_trig = cyc;
    end
    if (frame_done_o) begin
      last_done = cyc;
      done_cnt++;
    end
    if (sbit_valid_o) sbit_cnt++;
    if (sdata_o) one_cnt++;
    if (ready_o && !prev_ready) rise_q.push_back(cyc);
    prev_ready = ready_o;
    if (cyc >= 11 && cyc <= 34) basic_bits = {basic_bits[WIDTH-2:0], sdata_o};
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input logic [DIV_W-1:0] d, input bit msb);
    int n;
    n           = 0;
    data_i      = w;
    div_i       = d;
    msb_first_i = msb;
    valid_i     = 1'b1;
    accepted    = 1'b0;
    while (!accepted && n < 2000) begin
      step();
      n++;
    end
    valid_i = 1'b0;
    check("send_accept", 32'(accepted), 32'd1);
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    sbit_cnt = 0;
    one_cnt  = 0;
  endtask

  initial begin
    int d;
    reset_i     = 1'b1;
    valid_i     = 1'b0;
    data_i      = '0;
    div_i       = '0;
    msb_first_i = 1'b1;
    run(3);
    reset_i = 1'b0;
    while (cyc < 10) step();

    send(24'hA5C3F0, 8'd0, 1'b1);
    run(WIDTH + GAP + 4);
    check("basic_trig", 32'(last_trig), 32'd11);
    check("basic_done", 32'(last_done), 32'd35);
    check("basic_bits", 32'(basic_bits), 32'h00A5C3F0);
    check("basic_ready", 32'(rise_q.size() > 1 ? rise_q[1] : -1), 32'd38);

    clear_counts();
    send(24'h000001, 8'd3, 1'b0);
    run(4 * WIDTH + GAP + 2);
    check("lsb_strobes", 32'(sbit_cnt), 32'd24);
    check("lsb_ones", 32'(one_cnt), 32'd4);

    send(24'hFFFFFF, 8'd0, 1'b1);
    send(24'h000000, 8'd0, 1'b1);
    check("b2b_spacing", 32'(last_trig - prev_trig), 32'd28);
    run(WIDTH + GAP + 2);

    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 4);
      send(WIDTH'($urandom), DIV_W'(d), 1'($urandom_range(0, 1)));
      for (int i = 0; i < WIDTH * (d + 1); i++) begin
        valid_i     = 1'($urandom_range(0, 1));
        data_i      = WIDTH'($urandom);
        div_i       = DIV_W'($urandom);
        msb_first_i = 1'($urandom_range(0, 1));
        step();
      end
      valid_i = 1'b0;
      run(GAP + 3);
      check($sformatf("freeze_period%0d", it), 32'(last_done - last_trig), 32'(WIDTH * (d + 1)));
    end

    clear_counts();
    send(24'h5A5A5A, 8'd0, 1'b1);
    run(10);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("rst_outs", 32'({ready_o, sdata_o, sbit_valid_o, trigger_o, frame_done_o, busy_o}), 32'd0);
    step();
    check("rst_ready", 32'(ready_o), 32'd1);
    run(30);
    check("rst_no_done", 32'(done_cnt), 32'd0);
    send(24'h3C96E1, 8'd1, 1'b0);
    run(2 * WIDTH + GAP + 2);
    check("rst_resume", 32'(last_done - last_trig), 32'd48);

    clear_counts();
    send(24'h800000, 8'd255, 1'b1);
    run(256 * WIDTH + GAP + 2);
    check("maxdiv_done", 32'(last_done - last_trig), 32'd6144);
    check("maxdiv_ones", 32'(one_cnt), 32'd256);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
